// File: rtl/channel_pkg.sv
// rtl/channel_pkg.sv - shared types and constants for the channel transmit stage
package channel_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [30:0]  DEFAULT_SYNC_PATTERN = 31'h2AAA_AAAA;
    localparam logic [127:0] IDLE_WORD            = '0;

    // The valid flag always sits in the top bit of a channel word.
    function automatic int flag_bit(input int dwidth);
        return dwidth - 1;
    endfunction

endpackage

// File: rtl/channel_tx_if.sv
// rtl/channel_tx_if.sv - local payload valid/ready handshake into channel_tx
interface channel_tx_if #(
    parameter int DWIDTH = 32
) ();
    logic              in_valid;
    logic [DWIDTH-2:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/channel_credit_counter.sv
// rtl/channel_credit_counter.sv - far-end credit register with saturation and sticky overflow
module channel_credit_counter #(
    parameter int  CREDITS = 8,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_credits,
    output logic          o_ovf_evt,
    output logic          o_ovf
);
    logic [CW-1:0] r_credits;
    logic          r_ovf;

    // A returned credit with nothing in flight to absorb it means the far end lied.
    assign o_ovf_evt = i_inc && !i_dec && (r_credits == CW'(CREDITS));
    assign o_credits = r_credits;
    assign o_ovf     = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CW'(CREDITS);
            r_ovf     <= 1'b0;
        end else begin
            case ({i_inc, i_dec})
                2'b10: begin
                    if (o_ovf_evt) r_ovf <= 1'b1;
                    else           r_credits <= r_credits + 1'b1;
                end
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end
endmodule

// File: rtl/channel_tx.sv
// rtl/channel_tx.sv - credit-throttled transmit stage with link-sync preamble
// Optional transfer counter port o_tx_count when CHANNEL_TX_STATS_EN is defined.
module channel_tx
    import channel_pkg::*;
#(
    parameter int                DWIDTH       = 32,
    parameter int                CREDITS      = 8,
    parameter int                SYNC_CYCLES  = 4,
    parameter logic [DWIDTH-2:0] SYNC_PATTERN = DEFAULT_SYNC_PATTERN,
    localparam int               CW           = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    channel_tx_if.slave       up,
    input  logic              i_credit_in,
    output logic [DWIDTH-1:0] o_chan_out,
    output logic [CW-1:0]     o_credits,
    output logic              o_link_up,
    output logic              o_err
`ifdef CHANNEL_TX_STATS_EN
    ,
    output logic [31:0]       o_tx_count
`endif
);
    localparam int FLAG_BIT = flag_bit(DWIDTH);
    localparam int SCW      = $clog2(SYNC_CYCLES + 1);

    state_t            r_state;
    logic [SCW-1:0]    r_sync_cnt;
    logic [DWIDTH-1:0] r_chan_out;
    logic [DWIDTH-1:0] w_data_word;
    logic [CW-1:0]     w_credits;
    logic              w_xfer;
    logic              w_ovf_evt;
    logic              w_ovf;

    assign up.in_ready = (r_state == RUN) && (w_credits != '0);
    assign w_xfer      = up.in_valid && up.in_ready;

    always_comb begin
        w_data_word           = {1'b0, up.in_data};
        w_data_word[FLAG_BIT] = 1'b1;
    end

    channel_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_inc     (i_credit_in),
        .i_dec     (w_xfer),
        .o_credits (w_credits),
        .o_ovf_evt (w_ovf_evt),
        .o_ovf     (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SYNC;
            r_sync_cnt <= '0;
            r_chan_out <= IDLE_WORD[DWIDTH-1:0];
        end else begin
            case (r_state)
                SYNC: begin
                    // An overflow seen during the preamble is only acted on at its end.
                    if (r_sync_cnt == SCW'(SYNC_CYCLES)) begin
                        r_chan_out <= IDLE_WORD[DWIDTH-1:0];
                        r_state    <= (w_ovf || w_ovf_evt) ? ERR : RUN;
                    end else begin
                        r_chan_out <= {1'b0, SYNC_PATTERN};
                        r_sync_cnt <= r_sync_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_chan_out <= w_xfer ? w_data_word : IDLE_WORD[DWIDTH-1:0];
                    if (w_ovf_evt) r_state <= ERR;
                end
                default: begin
                    r_chan_out <= IDLE_WORD[DWIDTH-1:0];
                    r_state    <= ERR;
                end
            endcase
        end
    end

`ifdef CHANNEL_TX_STATS_EN
    logic [31:0] r_tx_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_tx_count <= '0;
        else if (w_xfer) r_tx_count <= r_tx_count + 32'd1;
    end

    assign o_tx_count = r_tx_count;
`endif

    assign o_chan_out = r_chan_out;
    assign o_credits  = w_credits;
    assign o_link_up  = (r_state == RUN);
    assign o_err      = w_ovf;
endmodule

// File: doc/channel_tx.md
Name: channel_tx

Overview:
- Transmit stage directly upstream of the fixed-latency delay channel in the distributed array.
- Accepts payload words from the local node over a valid/ready handshake.
- Tags each accepted word with a valid flag and drives it into the channel input.
- Throttles with credit-based flow control, because the far end has a finite receive buffer and credits return through a separate delay channel. Also emits a link-sync preamble after reset.

Parameters:
- DWIDTH, 32, channel word width; payload width is DWIDTH-1.
- CREDITS, 8, receive-buffer depth at the far end; initial credit count (1..255).
- SYNC_CYCLES, 4, number of sync words emitted after reset (>=1).
- SYNC_PATTERN, 31'h2AAA_AAAA, payload of a sync word (DWIDTH-1 bits, must be nonzero).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  local payload valid
- in_data  input  DWIDTH-1  local payload
- in_ready  output  1  channel_tx accepts in_data this cycle
- credit_in  input  1  one-cycle pulse; one far-end buffer slot freed
- chan_out  output  DWIDTH  word driven into channel data_in
- credits  output  $clog2(CREDITS+1)  current credit count
- link_up  output  1  high in RUN state
- err  output  1  sticky credit-overflow error

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. Reset values:
  - chan_out = 0
  - credits = CREDITS
  - in_ready = 0
  - link_up = 0
  - err = 0
  - state = SYNC
  - sync counter = 0
- Word format: bit DWIDTH-1 is the valid flag. Data word = {1, payload}. Idle word = all zeros. Sync word = {0, SYNC_PATTERN}.
- FSM states: SYNC, RUN, ERR.
  - SYNC: chan_out = sync word each cycle; in_ready = 0. Counter increments each cycle. After SYNC_CYCLES sync words, transition to RUN; the first RUN cycle outputs idle or data.
  - RUN: link_up = 1; in_ready = (credits != 0), combinational from the credits register. Transfer occurs when in_valid && in_ready.
    - On a transfer at edge N, chan_out = {1, in_data} from edge N until the next edge. Latency is 1 cycle into the channel.
    - Without a transfer, chan_out = 0 at the next edge.
  - ERR: entered from RUN on credit overflow. in_ready = 0, chan_out = 0, link_up = 0, err = 1. Exit only by reset.
- Credit arithmetic, unsigned, width $clog2(CREDITS+1):
  - Transfer only: credits - 1.
  - credit_in only: credits + 1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Boundary conditions:
  - credits == 0: in_ready = 0. A credit_in in that cycle raises credits to 1, so in_ready goes high the next cycle (no combinational credit_in→in_ready path).
  - Overflow: credit_in while credits == CREDITS with no same-cycle transfer → credits holds at CREDITS, err set, state goes to ERR next cycle.
  - credit_in during SYNC: counted with the same saturation/overflow rule. Overflow in SYNC sets err; the transition to ERR happens on SYNC exit.
- in_data is ignored when in_ready = 0. in_valid may be held high across stall cycles without penalty.
- Reset asserted mid-operation: all state returns to reset values immediately; SYNC restarts on deassertion.

Optional Feature:
- Macro CHANNEL_TX_STATS_EN.
- When defined: adds output port tx_count (32-bit). It counts accepted transfers, wraps from 0xFFFF_FFFF to 0, resets to 0, and holds in ERR.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package channel_pkg:
  - flag bit index function of DWIDTH
  - state enum {SYNC, RUN, ERR}
  - default SYNC_PATTERN constant
  - idle word constant
- Sub-module channel_credit_counter: credit register, inc/dec/saturate logic and overflow flag. Instantiated once.

Test Plan (DWIDTH=32, CREDITS=4, SYNC_CYCLES=4):
- Reset release → exactly 4 cycles of chan_out=0x2AAAAAAA with in_ready=0, then link_up=1, in_ready=1, credits=4.
- in_valid held with in_data=0x11,0x22,... and no credit_in → 4 words seen as 0x80000011..0x80000044 on consecutive cycles; credits reaches 0; in_ready=0; chan_out=0 afterwards.
- At credits=0, pulse credit_in once → credits=1, in_ready=1 next cycle; one more word sent; credits=0 again.
- Transfer and credit_in in the same cycle at credits=2 → credits stays 2; word appears on chan_out next cycle.
- credit_in at credits=4 with no transfer → err=1; state ERR next cycle; in_ready=0; chan_out=0 until rst_n pulse; then SYNC sequence repeats.
- Assert rst_n low mid-burst → chan_out=0 and credits=4 without waiting for a clock edge.
